display_scan_controller: RTL
============================

// Module: display_scan_controller
// PURPOSE
//  Time-multiplexes one hex-to-7-segment decoder (DisplayController) across NUM_DIGITS common-anode digits.
//  Holds a tear-free display buffer, scans digits at a fixed refresh rate and inserts anode-off dead time against ghosting.
//  Sits between the value-producing logic and the board segment/anode pins.
// PARAMETERS
//  NUM_DIGITS    4      number of digits scanned (>=2)
//  REFRESH_DIV   50000  Clk cycles each digit is lit (SHOW length, >=1)
//  BLANK_CYCLES  16     Clk cycles of all-anodes-off between digits (0 = no blanking)
// PORTS
//  Clk         in   1             system clock, all logic on rising edge
//  Reset_n     in   1             synchronous reset, active-low
//  DataIn      in   4*NUM_DIGITS  digit nibbles, [3:0] = digit 0 (rightmost)
//  LoadStrobe  in   1             1-cycle pulse: capture DataIn into pending buffer
//  DigitEn     in   NUM_DIGITS    per-digit enable; 0 = digit dark for its slot
//  SegmentOut  out  7             segments a..g, active-low, registered
//  AnodeOut    out  NUM_DIGITS    digit anodes, active-low one-cold (or all 1), registered
//  FrameDone   out  1             1-cycle pulse when last digit's slot ends
// BEHAVIOUR
//  Reset (Reset_n=0 at edge): AnodeOut=all 1, SegmentOut=7'h7F, FrameDone=0, digit index=0,
//   pending=active=0, counter=0, state=BLANK. Reset mid-scan aborts immediately; no partial pulse.
//  FSM: BLANK -> SHOW after BLANK_CYCLES cycles (immediately if BLANK_CYCLES=0);
//   SHOW -> BLANK (or SHOW of next digit if BLANK_CYCLES=0) after REFRESH_DIV cycles.
//  Leaving SHOW advances index; index NUM_DIGITS-1 wraps to 0 and asserts FrameDone that cycle.
//  SHOW: AnodeOut bit[index]=0 iff DigitEn[index]=1, others 1; SegmentOut=decode(active nibble[index]).
//  BLANK, or SHOW with digit disabled: AnodeOut=all 1, SegmentOut=7'h7F. Disabled digits still consume slot.
//  Outputs registered: anode and segment change on the same edge, 1 cycle after state/index update.
//  Buffering: LoadStrobe -> pending<=DataIn. At frame boundary active<=pending; if LoadStrobe on that
//   same cycle, active<=DataIn (bypass). Strobes mid-frame never alter the digit being shown.
//  Multiple strobes in one frame: last one wins. DigitEn is sampled live (no buffering).
//  Counter width $clog2(max(REFRESH_DIV,BLANK_CYCLES)+1); counts 0..N-1, reloads to 0 on state change.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: digits above the most-significant nonzero nibble of active are forced
//   dark (as if DigitEn=0); digit 0 always shown, so value 0 displays "0".
//  Not defined: every enabled digit shown, leading zeros included. No other behaviour differs.
// STRUCTURE
//  Shared header display_defs.vh: state encodings ST_BLANK/ST_SHOW, SEG_OFF=7'h7F, ANODE_OFF helper.
//  One sub-module: DisplayController (existing 4-bit hex -> 7-seg decoder), instantiated once,
//   fed by the index-selected nibble; its output is registered here.
//  Scan counter, index, buffers, FSM, leading-zero logic stay in this module.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 unless noted)
//  Reset held 3 cycles -> AnodeOut=4'hF, SegmentOut=7'h7F, FrameDone=0 throughout.
//  LoadStrobe with DataIn=16'h1234, DigitEn=4'hF -> next frame: slots show 4,3,2,1 on anodes
//   4'hE,4'hD,4'hB,4'h7, 4 cycles each, 1-cycle all-off gaps; FrameDone every 20 cycles.
//  Strobe 16'hAAAA mid-frame then 16'h5555 same frame -> current frame unchanged; next frame all 5s.
//  Strobe 16'h0F00 on the FrameDone cycle -> following frame shows 0F00 (bypass), not stale pending.
//  DigitEn=4'b0101 -> anodes 4'hE and 4'hB only; digits 1,3 slots all-off, frame length still 20.
//  BLANK_CYCLES=0 -> no all-off cycles; anode steps E,D,B,7 every 4 cycles.
//  LEADING_ZERO_BLANK_EN, DataIn=16'h0007 -> only digit 0 lit ("7"); 16'h0000 -> digit 0 shows "0".
//  Reset_n pulsed low during digit 2 SHOW -> outputs off next edge; scan restarts at digit 0, buffers 0.

Source files
------------

// File: rtl/display_scan_controller_pkg.sv
// Shared definitions for the display scan controller: FSM state codes, segment-off pattern, helpers.
// Optional LEADING_ZERO_BLANK_EN is handled in display_scan_controller.sv.
package display_scan_controller_pkg;

    typedef logic [0:0] scan_state_t;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_scan_controller_decoder.sv
// Hex nibble to 7-segment decoder (the DisplayController function), combinational.
// o_seg is active-low, bit 0 = segment a ... bit 6 = segment g.
module display_scan_controller_decoder (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_nibble)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed common-anode display scanner with double-buffered digits and anode-off dead time.
// Define LEADING_ZERO_BLANK_EN to darken digits above the most-significant nonzero nibble.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [4*NUM_DIGITS-1:0] DataIn,
    input  logic                    LoadStrobe,
    input  logic [NUM_DIGITS-1:0]   DigitEn,
    output logic [6:0]              SegmentOut,
    output logic [NUM_DIGITS-1:0]   AnodeOut,
    output logic                    FrameDone
);

    localparam int CW = $clog2(max_int(REFRESH_DIV, BLANK_CYCLES) + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    // With no blanking the BLANK state only exists for the single cycle after reset.
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT0_BIT = NUM_DIGITS'(1);

    scan_state_t               r_state;
    logic [IW-1:0]             r_index;
    logic [CW-1:0]             r_cnt;
    logic [4*NUM_DIGITS-1:0]   r_pending;
    logic [4*NUM_DIGITS-1:0]   r_active;
    logic [6:0]                r_seg;
    logic [NUM_DIGITS-1:0]     r_anode;

    logic                      w_show;
    logic                      w_show_end;
    logic                      w_blank_end;
    logic                      w_frame_end;
    logic                      w_lz_dark;
    logic                      w_lit;
    logic [3:0]                w_nibble;
    logic [6:0]                w_seg;

    assign w_show      = (r_state == ST_SHOW);
    assign w_show_end  = w_show && (r_cnt == SHOW_LAST);
    assign w_blank_end = !w_show && (r_cnt == BLANK_LAST);
    assign w_frame_end = w_show_end && (r_index == LAST_IDX);

    assign w_nibble = r_active[{r_index, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [IW-1:0] w_msd;

    always_comb begin
        w_msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_active[4*i +: 4] != 4'h0) begin
                w_msd = IW'(i);
            end
        end
    end

    assign w_lz_dark = (r_index > w_msd);
`else
    assign w_lz_dark = 1'b0;
`endif

    assign w_lit = w_show && DigitEn[r_index] && !w_lz_dark;

    display_scan_controller_decoder u_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state   <= ST_BLANK;
            r_index   <= '0;
            r_cnt     <= '0;
            r_pending <= '0;
            r_active  <= '0;
            r_seg     <= SEG_OFF;
            r_anode   <= '1;
        end else begin
            if (w_show_end) begin
                r_state <= (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                r_index <= (r_index == LAST_IDX) ? '0 : r_index + IW'(1);
                r_cnt   <= '0;
            end else if (w_blank_end) begin
                r_state <= ST_SHOW;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            // A strobe landing on the frame boundary goes straight to the active buffer.
            if (w_frame_end) begin
                r_active <= LoadStrobe ? DataIn : r_pending;
            end
            if (LoadStrobe) begin
                r_pending <= DataIn;
            end

            r_seg   <= w_lit ? w_seg : SEG_OFF;
            r_anode <= w_lit ? ~(DIGIT0_BIT << r_index) : '1;
        end
    end

    assign SegmentOut = r_seg;
    assign AnodeOut   = r_anode;
    assign FrameDone  = w_frame_end;

endmodule
